// File: rtl/fpu_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : fpu_pkg
//  Description : Shared types and register map for the FPU Wishbone bridge.
//  Revision    : 1.0 - initial release
// ============================================================================
package fpu_pkg;

    localparam int FLAGS_W = 5;

    typedef enum logic [2:0] {
        OP_ADD  = 3'd0,
        OP_SUB  = 3'd1,
        OP_MUL  = 3'd2,
        OP_DIV  = 3'd3,
        OP_SQRT = 3'd4,
        OP_CMP  = 3'd5
    } fpu_opcode_e;

    typedef enum logic [2:0] {
        RM_RNE = 3'd0,
        RM_RTZ = 3'd1,
        RM_RDN = 3'd2,
        RM_RUP = 3'd3,
        RM_RMM = 3'd4
    } fpu_rm_e;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2
    } fpu_state_e;

    localparam logic [7:0] c_OFF_OP_A   = 8'h00;
    localparam logic [7:0] c_OFF_OP_B   = 8'h04;
    localparam logic [7:0] c_OFF_CTRL   = 8'h08;
    localparam logic [7:0] c_OFF_STATUS = 8'h0C;
    localparam logic [7:0] c_OFF_RESULT = 8'h10;
    localparam logic [7:0] c_OFF_FLAGS  = 8'h14;

    // Merge a bus write into a 32-bit register, honouring byte enables.
    function automatic logic [31:0] apply_sel(input logic [31:0] old_val,
                                              input logic [31:0] new_val,
                                              input logic [3:0]  sel);
        logic [31:0] w_res;
        w_res = old_val;
        for (int i = 0; i < 4; i++) begin
            if (sel[i]) w_res[i*8 +: 8] = new_val[i*8 +: 8];
        end
        return w_res;
    endfunction

endpackage
`default_nettype wire

// File: rtl/fpu_result_fifo.sv
`default_nettype none
// ============================================================================
//  Module      : fpu_result_fifo
//  Description : Synchronous FIFO holding {flags, result} entries with count.
//  Revision    : 1.0 - initial release
// ============================================================================
module fpu_result_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 37
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     i_push,
    input  logic [WIDTH-1:0]         i_data,
    input  logic                     i_pop,
    output logic [WIDTH-1:0]         o_head,
    output logic [$clog2(DEPTH):0]   o_count,
    output logic                     o_full,
    output logic                     o_empty
);
    localparam int c_PTR_W = $clog2(DEPTH);

    logic [WIDTH-1:0]   r_mem [DEPTH];
    logic [c_PTR_W-1:0] r_wptr;
    logic [c_PTR_W-1:0] r_rptr;
    logic [c_PTR_W:0]   r_count;
    logic               w_do_push;
    logic               w_do_pop;

    assign o_full    = (r_count == (c_PTR_W+1)'(DEPTH));
    assign o_empty   = (r_count == '0);
    // A full FIFO may still accept a push when an entry leaves the same cycle.
    assign w_do_push = i_push & (~o_full | i_pop);
    assign w_do_pop  = i_pop & ~o_empty;
    assign o_head    = r_mem[r_rptr];
    assign o_count   = r_count;

    always_ff @(posedge clk) begin
        if (w_do_push) r_mem[r_wptr] <= i_data;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else begin
            if (w_do_push) r_wptr <= r_wptr + 1'b1;
            if (w_do_pop)  r_rptr <= r_rptr + 1'b1;
            case ({w_do_push, w_do_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: rtl/fpu_wb_bridge.sv
`default_nettype none
// ============================================================================
//  Module      : fpu_wb_bridge
//  Description : Wishbone slave launching FPU operations and queueing results.
//                Optional WAIT timeout enabled by FPU_WB_TIMEOUT_EN.
//  Revision    : 1.0 - initial release
// ============================================================================
module fpu_wb_bridge
    import fpu_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR      = 32'h3000_0000,
    parameter int          RESULT_DEPTH   = 4,
    parameter int          TIMEOUT_CYCLES = 255
) (
    input  logic         wb_clk_i,
    input  logic         wb_rst_i,
    input  logic         wbs_cyc_i,
    input  logic         wbs_stb_i,
    input  logic         wbs_we_i,
    input  logic [3:0]   wbs_sel_i,
    input  logic [31:0]  wbs_adr_i,
    input  logic [31:0]  wbs_dat_i,
    output logic         wbs_ack_o,
    output logic [31:0]  wbs_dat_o,
    output logic [31:0]  fpu_op_a_o,
    output logic [31:0]  fpu_op_b_o,
    output logic [2:0]   fpu_opcode_o,
    output logic [2:0]   fpu_rm_o,
    output logic         fpu_start_o,
    input  logic         fpu_done_i,
    input  logic [31:0]  fpu_result_i,
    input  logic [4:0]   fpu_flags_i,
    output logic         irq_o
);
    localparam int c_CNT_W   = $clog2(RESULT_DEPTH) + 1;
    localparam int c_ENTRY_W = FLAGS_W + 32;

    fpu_state_e           r_state;
    fpu_state_e           w_state_nxt;
    logic [31:0]          r_op_a;
    logic [31:0]          r_op_b;
    logic [2:0]           r_opcode;
    logic [2:0]           r_rm;
    logic                 r_irq_en;
    logic                 r_timeout;
    logic                 r_reject;
    logic                 r_ack;
    logic                 r_pop_ok;
    logic [31:0]          r_dat;
    logic [31:0]          w_rdata;
    logic [7:0]           w_off;
    logic                 w_req;
    logic                 w_sample;
    logic                 w_wr;
    logic                 w_idle;
    logic                 w_go;
    logic                 w_go_ok;
    logic                 w_push;
    logic                 w_timeout_hit;
    logic                 w_start;
    logic [c_ENTRY_W-1:0] w_head;
    logic [c_CNT_W-1:0]   w_count;
    logic                 w_full;
    logic                 w_empty;
    logic [3:0]           w_cnt4;
    logic                 w_unused_ok;

    // Read data is captured when the request is first seen; side effects
    // (register writes, GO, pops) happen in the following ack cycle.
    assign w_req    = wbs_cyc_i & wbs_stb_i & (wbs_adr_i[31:8] == BASE_ADDR[31:8]);
    assign w_sample = w_req & ~r_ack;
    assign w_wr     = w_req & r_ack & wbs_we_i;
    assign w_off    = {wbs_adr_i[7:2], 2'b00};
    assign w_idle   = (r_state == ST_IDLE);
    assign w_go     = w_wr & (w_off == c_OFF_CTRL) & wbs_sel_i[3] & wbs_dat_i[31];
    assign w_go_ok  = w_go & w_idle & ~w_full;
    assign w_push   = (r_state == ST_WAIT) & fpu_done_i;
    assign w_cnt4   = 4'(w_count);

`ifdef FPU_WB_TIMEOUT_EN
    localparam int c_TO_W = $clog2(TIMEOUT_CYCLES + 1);
    logic [c_TO_W-1:0] r_wait_cnt;

    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i || r_state != ST_WAIT) r_wait_cnt <= '0;
        else                                r_wait_cnt <= r_wait_cnt + c_TO_W'(1);
    end

    // A done arriving in the terminal cycle takes priority over the timeout.
    assign w_timeout_hit = (r_state == ST_WAIT) & ~fpu_done_i &
                           (r_wait_cnt == c_TO_W'(TIMEOUT_CYCLES - 1));
    assign w_unused_ok   = ^wbs_adr_i[1:0];
`else
    assign w_timeout_hit = 1'b0;
    assign w_unused_ok   = ^{wbs_adr_i[1:0], (TIMEOUT_CYCLES != 0)};
`endif

    fpu_result_fifo #(
        .DEPTH (RESULT_DEPTH),
        .WIDTH (c_ENTRY_W)
    ) u_result_fifo (
        .clk     (wb_clk_i),
        .rst     (wb_rst_i),
        .i_push  (w_push),
        .i_data  ({fpu_flags_i, fpu_result_i}),
        .i_pop   (r_pop_ok),
        .o_head  (w_head),
        .o_count (w_count),
        .o_full  (w_full),
        .o_empty (w_empty)
    );

    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) r_state <= ST_IDLE;
        else          r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        w_start     = 1'b0;
        case (r_state)
            ST_IDLE:  if (w_go_ok) w_state_nxt = ST_ISSUE;
            ST_ISSUE: begin
                w_start     = 1'b1;
                w_state_nxt = ST_WAIT;
            end
            ST_WAIT:  if (fpu_done_i || w_timeout_hit) w_state_nxt = ST_IDLE;
            default:  w_state_nxt = ST_IDLE;
        endcase
    end

    always_comb begin
        w_rdata = '0;
        case (w_off)
            c_OFF_OP_A:   w_rdata = r_op_a;
            c_OFF_OP_B:   w_rdata = r_op_b;
            c_OFF_CTRL:   w_rdata = {25'd0, r_irq_en, r_rm, r_opcode};
            c_OFF_STATUS: w_rdata = {23'd0, w_cnt4, r_reject, r_timeout,
                                     w_full, ~w_empty, ~w_idle};
            c_OFF_RESULT: w_rdata = w_empty ? 32'd0 : w_head[31:0];
            c_OFF_FLAGS:  w_rdata = w_empty ? 32'd0 : {27'd0, w_head[c_ENTRY_W-1:32]};
            default:      w_rdata = '0;
        endcase
    end

    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            r_ack    <= 1'b0;
            r_dat    <= '0;
            r_pop_ok <= 1'b0;
        end else begin
            r_ack    <= w_sample;
            r_dat    <= (w_sample & ~wbs_we_i) ? w_rdata : 32'd0;
            // Only pop an entry that was actually returned on this read.
            r_pop_ok <= w_sample & ~wbs_we_i & (w_off == c_OFF_RESULT) & ~w_empty;
        end
    end

    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            r_op_a    <= '0;
            r_op_b    <= '0;
            r_opcode  <= '0;
            r_rm      <= '0;
            r_irq_en  <= 1'b0;
            r_timeout <= 1'b0;
            r_reject  <= 1'b0;
        end else begin
            if (w_wr && w_idle) begin
                case (w_off)
                    c_OFF_OP_A: r_op_a <= apply_sel(r_op_a, wbs_dat_i, wbs_sel_i);
                    c_OFF_OP_B: r_op_b <= apply_sel(r_op_b, wbs_dat_i, wbs_sel_i);
                    c_OFF_CTRL: if (wbs_sel_i[0]) {r_irq_en, r_rm, r_opcode} <= wbs_dat_i[6:0];
                    default: ;
                endcase
            end
            if (w_wr && w_off == c_OFF_STATUS && wbs_sel_i[0]) begin
                if (wbs_dat_i[3]) r_timeout <= 1'b0;
                if (wbs_dat_i[4]) r_reject  <= 1'b0;
            end
            if (w_go && !w_go_ok) r_reject  <= 1'b1;
            if (w_timeout_hit)    r_timeout <= 1'b1;
        end
    end

    assign wbs_ack_o    = r_ack;
    assign wbs_dat_o    = r_dat;
    assign fpu_op_a_o   = r_op_a;
    assign fpu_op_b_o   = r_op_b;
    assign fpu_opcode_o = r_opcode;
    assign fpu_rm_o     = r_rm;
    assign fpu_start_o  = w_start;
    assign irq_o        = r_irq_en & ~w_empty;

endmodule
`default_nettype wire

// File: tb/tb_fpu_wb_bridge.sv
`default_nettype none
// ============================================================================
//  Module      : tb_fpu_wb_bridge
//  Description : Self-checking bench for fpu_wb_bridge with an FPU responder.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_fpu_wb_bridge;
    localparam int          DEPTH  = 4;
    localparam int          TMO    = 10;
    localparam logic [31:0] A_OPA  = 32'h3000_0000;
    localparam logic [31:0] A_OPB  = 32'h3000_0004;
    localparam logic [31:0] A_CTRL = 32'h3000_0008;
    localparam logic [31:0] A_STAT = 32'h3000_000C;
    localparam logic [31:0] A_RES  = 32'h3000_0010;
    localparam logic [31:0] A_FLG  = 32'h3000_0014;
    localparam logic [31:0] A_GAP  = 32'h3000_0020;
    localparam logic [31:0] GO     = 32'h8000_0000;

    logic        wb_clk_i = 1'b0;
    logic        wb_rst_i = 1'b1;
    logic        wbs_cyc_i = 1'b0, wbs_stb_i = 1'b0, wbs_we_i = 1'b0;
    logic [3:0]  wbs_sel_i = 4'h0;
    logic [31:0] wbs_adr_i = '0, wbs_dat_i = '0;
    logic        wbs_ack_o;
    logic [31:0] wbs_dat_o, fpu_op_a_o, fpu_op_b_o;
    logic [2:0]  fpu_opcode_o, fpu_rm_o;
    logic        fpu_start_o, irq_o;
    logic        fpu_done_i = 1'b0;
    logic [31:0] fpu_result_i = '0;
    logic [4:0]  fpu_flags_i = '0;

    int          total = 0, bad = 0;
    int          start_cnt = 0;
    int          pulse_req = 0, pulse_ack = 0;
    bit          resp_en = 1'b1;
    int          resp_delay = 3;
    logic [31:0] resp_result = '0;
    logic [4:0]  resp_flags = '0;
    logic [36:0] exp_q [$];
    bit          m_reject = 1'b0, m_timeout = 1'b0;

    always #5 wb_clk_i = ~wb_clk_i;

    fpu_wb_bridge #(
        .BASE_ADDR      (32'h3000_0000),
        .RESULT_DEPTH   (DEPTH),
        .TIMEOUT_CYCLES (TMO)
    ) dut (
        .wb_clk_i     (wb_clk_i),
        .wb_rst_i     (wb_rst_i),
        .wbs_cyc_i    (wbs_cyc_i),
        .wbs_stb_i    (wbs_stb_i),
        .wbs_we_i     (wbs_we_i),
        .wbs_sel_i    (wbs_sel_i),
        .wbs_adr_i    (wbs_adr_i),
        .wbs_dat_i    (wbs_dat_i),
        .wbs_ack_o    (wbs_ack_o),
        .wbs_dat_o    (wbs_dat_o),
        .fpu_op_a_o   (fpu_op_a_o),
        .fpu_op_b_o   (fpu_op_b_o),
        .fpu_opcode_o (fpu_opcode_o),
        .fpu_rm_o     (fpu_rm_o),
        .fpu_start_o  (fpu_start_o),
        .fpu_done_i   (fpu_done_i),
        .fpu_result_i (fpu_result_i),
        .fpu_flags_i  (fpu_flags_i),
        .irq_o        (irq_o)
    );

    always @(negedge wb_clk_i) if (fpu_start_o === 1'b1) start_cnt <= start_cnt + 1;

    // FPU stand-in: answers a start after resp_delay cycles, or emits a stray
    // done pulse whenever the main sequence requests one.
    initial begin
        forever begin
            @(negedge wb_clk_i);
            if (pulse_req != pulse_ack) begin
                @(posedge wb_clk_i); #1;
                fpu_done_i = 1'b1; fpu_result_i = 32'hDEAD_BEEF; fpu_flags_i = 5'h1F;
                @(posedge wb_clk_i); #1;
                fpu_done_i = 1'b0;
                pulse_ack  = pulse_ack + 1;
            end else if (fpu_start_o === 1'b1 && resp_en) begin
                repeat (resp_delay) @(posedge wb_clk_i);
                #1;
                fpu_done_i = 1'b1; fpu_result_i = resp_result; fpu_flags_i = resp_flags;
                @(posedge wb_clk_i); #1;
                fpu_done_i = 1'b0;
            end
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] exp_status(input bit busy);
        int n;
        n = exp_q.size();
        exp_status      = '0;
        exp_status[0]   = busy;
        exp_status[1]   = (n != 0);
        exp_status[2]   = (n == DEPTH);
        exp_status[3]   = m_timeout;
        exp_status[4]   = m_reject;
        exp_status[8:5] = 4'(n);
    endfunction

    task automatic wb(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s,
                      input logic we, output logic [31:0] q);
        int n;
        @(posedge wb_clk_i); #1;
        wbs_cyc_i = 1'b1; wbs_stb_i = 1'b1; wbs_we_i = we;
        wbs_adr_i = a; wbs_dat_i = d; wbs_sel_i = s;
        n = 0;
        do begin
            @(posedge wb_clk_i); #1;
            n++;
        end while (wbs_ack_o !== 1'b1 && n < 8);
        q = wbs_dat_o;
        check("wb_ack", 32'(wbs_ack_o), 32'd1);
        @(posedge wb_clk_i); #1;
        wbs_cyc_i = 1'b0; wbs_stb_i = 1'b0; wbs_we_i = 1'b0;
    endtask

    task automatic wait_idle();
        logic [31:0] q;
        int n;
        n = 0;
        do begin
            wb(A_STAT, 32'd0, 4'hF, 1'b0, q);
            n++;
        end while (q[0] === 1'b1 && n < 40);
        check("busy_clears", 32'(q[0]), 32'd0);
    endtask

    task automatic issue(input logic [31:0] a, input logic [31:0] b, input logic [6:0] ctl,
                         input logic [31:0] res, input logic [4:0] fl, input int dly);
        logic [31:0] q;
        int s0;
        wb(A_OPA, a, 4'hF, 1'b1, q);
        wb(A_OPB, b, 4'hF, 1'b1, q);
        check("op_a_out", fpu_op_a_o, a);
        check("op_b_out", fpu_op_b_o, b);
        resp_result = res; resp_flags = fl; resp_delay = dly; resp_en = 1'b1;
        s0 = start_cnt;
        wb(A_CTRL, GO | 32'(ctl), 4'hF, 1'b1, q);
        check("opcode_out", 32'(fpu_opcode_o), 32'(ctl[2:0]));
        check("rm_out", 32'(fpu_rm_o), 32'(ctl[5:3]));
        wait_idle();
        check("start_pulses", 32'(start_cnt - s0), 32'd1);
        exp_q.push_back({fl, res});
    endtask

    initial begin
        logic [31:0] q, a1;
        logic [36:0] e;
        int          s0;

        repeat (3) @(posedge wb_clk_i);
        #1;
        check("rst_ack", 32'(wbs_ack_o), 32'd0);
        check("rst_dat", wbs_dat_o, 32'd0);
        check("rst_op_a", fpu_op_a_o, 32'd0);
        check("rst_op_b", fpu_op_b_o, 32'd0);
        check("rst_ctl", {26'd0, fpu_opcode_o, fpu_rm_o}, 32'd0);
        check("rst_start_irq", {30'd0, fpu_start_o, irq_o}, 32'd0);
        wb_rst_i = 1'b0;
        wb(A_STAT, 32'd0, 4'hF, 1'b0, q);
        check("rst_status", q, 32'd0);

        // Byte lanes and unmapped space.
        wb(A_OPB, 32'hAABB_CCDD, 4'b0011, 1'b1, q);
        wb(A_OPB, 32'h1122_3344, 4'b1000, 1'b1, q);
        check("sel_op_b", fpu_op_b_o, 32'h1100_CCDD);
        wb(A_OPB, 32'd0, 4'hF, 1'b0, q);
        check("sel_readback", q, 32'h1100_CCDD);
        wb(A_GAP, 32'hFFFF_FFFF, 4'hF, 1'b1, q);
        wb(A_GAP, 32'd0, 4'hF, 1'b0, q);
        check("gap_read", q, 32'd0);
        wb(A_RES, 32'd0, 4'hF, 1'b0, q);
        check("empty_result", q, 32'd0);

        // 1.0 + 2.0 = 3.0
        issue(32'h3F80_0000, 32'h4000_0000, 7'h00, 32'h4040_0000, 5'h00, 3);
        wb(A_STAT, 32'd0, 4'hF, 1'b0, q);
        check("add_status", q, exp_status(1'b0));
        check("add_status_lit", q, 32'h22);
        e = exp_q.pop_front();
        wb(A_RES, 32'd0, 4'hF, 1'b0, q);
        check("add_result", q, e[31:0]);
        wb(A_STAT, 32'd0, 4'hF, 1'b0, q);
        check("add_status_after", q, 32'h00);

        // Fill the FIFO with random operations, then one rejected GO.
        for (int k = 0; k < DEPTH; k++) begin
            issue($urandom, $urandom, {1'b0, 3'($urandom_range(0, 4)), 3'($urandom_range(0, 5))},
                  $urandom, 5'($urandom), $urandom_range(1, 6));
        end
        check("irq_disabled", 32'(irq_o), 32'd0);
        wb(A_STAT, 32'd0, 4'hF, 1'b0, q);
        check("full_status", q, exp_status(1'b0));
        s0 = start_cnt;
        wb(A_CTRL, GO | 32'h0C, 4'hF, 1'b1, q);
        m_reject = 1'b1;
        repeat (6) @(posedge wb_clk_i);
        #1;
        check("full_no_start", 32'(start_cnt - s0), 32'd0);
        check("full_fields_upd", {26'd0, fpu_rm_o, fpu_opcode_o}, 32'h0C);
        wb(A_STAT, 32'd0, 4'hF, 1'b0, q);
        check("reject_status", q, exp_status(1'b0));
        wb(A_STAT, 32'h10, 4'hF, 1'b1, q);
        m_reject = 1'b0;
        wb(A_STAT, 32'd0, 4'hF, 1'b0, q);
        check("reject_cleared", q, exp_status(1'b0));
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            wb(A_FLG, 32'd0, 4'hF, 1'b0, q);
            check("drain_flags", q, {27'd0, e[36:32]});
            wb(A_RES, 32'd0, 4'hF, 1'b0, q);
            check("drain_result", q, e[31:0]);
        end
        wb(A_STAT, 32'd0, 4'hF, 1'b0, q);
        check("drained_status", q, exp_status(1'b0));

        // GO and OP_A writes while the FPU is busy are ignored.
        a1 = $urandom;
        wb(A_OPA, a1, 4'hF, 1'b1, q);
        resp_result = $urandom; resp_flags = 5'($urandom); resp_delay = 20; resp_en = 1'b1;
        s0 = start_cnt;
        wb(A_CTRL, GO | 32'h02, 4'hF, 1'b1, q);
        wb(A_CTRL, GO | 32'h01, 4'hF, 1'b1, q);
        m_reject = 1'b1;
        wb(A_OPA, ~a1, 4'hF, 1'b1, q);
        check("wait_op_a_stable", fpu_op_a_o, a1);
        check("wait_opcode_stable", 32'(fpu_opcode_o), 32'd2);
        wait_idle();
        check("wait_one_start", 32'(start_cnt - s0), 32'd1);
        exp_q.push_back({resp_flags, resp_result});
        wb(A_STAT, 32'd0, 4'hF, 1'b0, q);
        check("wait_reject_status", q, exp_status(1'b0));
        e = exp_q.pop_front();
        wb(A_RES, 32'd0, 4'hF, 1'b0, q);
        check("wait_result", q, e[31:0]);
        wb(A_STAT, 32'h10, 4'h1, 1'b1, q);
        m_reject = 1'b0;

        // 1.0 / 0.0 raises DZ; interrupt enabled, rm RTZ.
        issue(32'h3F80_0000, 32'h0000_0000, 7'h4B, 32'h7F80_0000, 5'h08, 4);
        wb(A_CTRL, 32'd0, 4'hF, 1'b0, q);
        check("ctrl_readback", q, 32'h4B);
        wb(A_FLG, 32'd0, 4'hF, 1'b0, q);
        check("div_flags", q, 32'h08);
        check("irq_pending", 32'(irq_o), 32'd1);
        wb(A_FLG, 32'd0, 4'hF, 1'b0, q);
        check("flags_no_pop", q, 32'h08);
        check("irq_still", 32'(irq_o), 32'd1);
        e = exp_q.pop_front();
        wb(A_RES, 32'd0, 4'hF, 1'b0, q);
        check("div_result", q, e[31:0]);
        check("irq_cleared", 32'(irq_o), 32'd0);

        // Stray done while idle must not push.
        pulse_req = pulse_req + 1;
        repeat (5) @(posedge wb_clk_i);
        wb(A_STAT, 32'd0, 4'hF, 1'b0, q);
        check("stray_done_ignored", q, exp_status(1'b0));

`ifdef FPU_WB_TIMEOUT_EN
        resp_en = 1'b0;
        wb(A_CTRL, GO | 32'h03, 4'hF, 1'b1, q);
        repeat (TMO - 1) @(posedge wb_clk_i);
        wb(A_STAT, 32'd0, 4'hF, 1'b0, q);
        check("tmo_last_wait", q, 32'h01);
        m_timeout = 1'b1;
        wait_idle();
        wb(A_STAT, 32'd0, 4'hF, 1'b0, q);
        check("tmo_status", q, exp_status(1'b0));
        wb(A_STAT, 32'h08, 4'hF, 1'b1, q);
        m_timeout = 1'b0;
        wb(A_CTRL, GO | 32'h03, 4'hF, 1'b1, q);
        repeat (TMO) @(posedge wb_clk_i);
        wb(A_STAT, 32'd0, 4'hF, 1'b0, q);
        m_timeout = 1'b1;
        check("tmo_exact_idle", q, exp_status(1'b0));
        pulse_req = pulse_req + 1;
        repeat (5) @(posedge wb_clk_i);
        wb(A_STAT, 32'd0, 4'hF, 1'b0, q);
        check("tmo_late_done", q, 32'h08);
        wb(A_STAT, 32'h08, 4'hF, 1'b1, q);
        m_timeout = 1'b0;
        issue($urandom, $urandom, 7'h00, 32'h1234_5678, 5'h01, TMO);
        wb(A_STAT, 32'd0, 4'hF, 1'b0, q);
        check("tmo_done_wins", q, exp_status(1'b0));
        e = exp_q.pop_front();
        wb(A_RES, 32'd0, 4'hF, 1'b0, q);
        check("tmo_done_result", q, e[31:0]);
`endif

        // Reset in the middle of WAIT, then a late done.
        resp_en = 1'b0;
        wb(A_OPA, 32'hCAFE_F00D, 4'hF, 1'b1, q);
        wb(A_CTRL, GO | 32'h44, 4'hF, 1'b1, q);
        repeat (3) @(posedge wb_clk_i);
        #1;
        wb_rst_i = 1'b1;
        repeat (2) @(posedge wb_clk_i);
        #1;
        wb_rst_i = 1'b0;
        exp_q.delete();
        m_reject = 1'b0; m_timeout = 1'b0;
        pulse_req = pulse_req + 1;
        repeat (5) @(posedge wb_clk_i);
        #1;
        check("rrst_outputs", {fpu_op_a_o ^ fpu_op_b_o}, 32'd0);
        check("rrst_op_a", fpu_op_a_o, 32'd0);
        check("rrst_ctl", {26'd0, fpu_opcode_o, fpu_rm_o}, 32'd0);
        check("rrst_start_irq_ack", {29'd0, fpu_start_o, irq_o, wbs_ack_o}, 32'd0);
        wb(A_STAT, 32'd0, 4'hF, 1'b0, q);
        check("rrst_status", q, exp_status(1'b0));
        wb(A_RES, 32'd0, 4'hF, 1'b0, q);
        check("rrst_result", q, 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
